// File: rtl/earom_nvram_bridge.sv
// earom_nvram_bridge
// Byte-wide EAROM shadow for the vector cores, clk_12 domain.
// The CPU reads and writes the shadow directly. The HPS restores it through
// the ioctl download path and saves it through the ioctl upload path.
// One single-port RAM is shared with a fixed priority:
//   CPU write > CPU read > HPS download write > HPS upload read.
// An HPS access that loses arbitration is parked in a pending entry and
// retried on the following cycle. At most two CPU cycles can win in a row,
// so an upload read always completes within three cycles.
module earom_nvram_bridge #(
  parameter logic [7:0] NV_INDEX = 8'd4,
  parameter int         ADDR_W   = 6
) (
  input  logic              clk_12,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  input  logic              save_trig,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_dout,
  output logic              dirty
);

  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam logic [24:0] DEPTH_A = 25'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_UPLOADING = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // Shadow storage
  logic [7:0]        mem_r [DEPTH];

  // Qualified HPS strobes
  logic              nv_sel_s;
  logic              dl_new_in_s;
  logic              up_new_s;
  logic              up_new_in_s;
  logic              up_new_oor_s;

  // Pending (lost-arbitration) HPS requests
  logic              dl_pend_r;
  logic [ADDR_W-1:0] dl_pend_addr_r;
  logic [7:0]        dl_pend_data_r;
  logic              up_pend_r;
  logic [ADDR_W-1:0] up_pend_addr_r;

  // Effective HPS requests this cycle (new strobe or retried pending)
  logic              dl_req_s;
  logic [ADDR_W-1:0] dl_addr_s;
  logic [7:0]        dl_data_s;
  logic              up_req_s;
  logic [ADDR_W-1:0] up_addr_s;

  // RAM port
  logic              grant_cpu_rd_s;
  logic              grant_dl_s;
  logic              grant_up_s;
  logic              port_we_s;
  logic [ADDR_W-1:0] port_addr_s;
  logic [7:0]        port_wdata_s;

  // Output and control registers
  logic [7:0]        cpu_dout_r;
  logic [7:0]        ioctl_din_r;
  state_t            state_r;
  logic              upload_req_r;
  logic              dirty_r;
  logic              wr_during_up_r;
  logic              save_trig_d_r;
  logic              upload_d_r;
  logic              download_d_r;

  // Edge detectors for the FSM
  logic              save_rise_s;
  logic              up_rise_s;
  logic              up_fall_s;
  logic              dl_rise_s;
  logic              dl_fall_s;

  // Qualify the raw ioctl strobes and split upload reads by address range.
  // Serving upload reads depends only on this qualifier, never on FSM state.
  always_comb begin
    nv_sel_s     = (ioctl_index == NV_INDEX);
    dl_new_in_s  = ioctl_download & nv_sel_s & ioctl_wr & (ioctl_addr < DEPTH_A);
    up_new_s     = ioctl_upload & nv_sel_s & ioctl_rd;
    up_new_in_s  = up_new_s & (ioctl_addr < DEPTH_A);
    up_new_oor_s = up_new_s & ~(ioctl_addr < DEPTH_A);
  end

  // Merge new HPS strobes with the pending entries. A new upload read always
  // replaces a pending one, including an out-of-range read that needs no RAM.
  always_comb begin
    dl_req_s  = 1'b0;
    dl_addr_s = dl_pend_addr_r;
    dl_data_s = dl_pend_data_r;
    if (dl_new_in_s) begin
      dl_req_s  = 1'b1;
      dl_addr_s = ioctl_addr[ADDR_W-1:0];
      dl_data_s = ioctl_dout;
    end else if (dl_pend_r) begin
      dl_req_s  = 1'b1;
    end else begin
      dl_req_s  = 1'b0;
    end

    up_req_s  = 1'b0;
    up_addr_s = up_pend_addr_r;
    if (up_new_in_s) begin
      up_req_s  = 1'b1;
      up_addr_s = ioctl_addr[ADDR_W-1:0];
    end else if (up_new_oor_s) begin
      up_req_s  = 1'b0;
    end else if (up_pend_r) begin
      up_req_s  = 1'b1;
    end else begin
      up_req_s  = 1'b0;
    end
  end

  // Fixed-priority arbitration of the single RAM port
  always_comb begin
    grant_cpu_rd_s = 1'b0;
    grant_dl_s     = 1'b0;
    grant_up_s     = 1'b0;
    port_we_s      = 1'b0;
    port_addr_s    = up_addr_s;
    port_wdata_s   = cpu_din;
    if (cpu_wr) begin
      port_we_s    = 1'b1;
      port_addr_s  = cpu_addr;
      port_wdata_s = cpu_din;
    end else if (cpu_rd) begin
      grant_cpu_rd_s = 1'b1;
      port_addr_s    = cpu_addr;
    end else if (dl_req_s) begin
      grant_dl_s   = 1'b1;
      port_we_s    = 1'b1;
      port_addr_s  = dl_addr_s;
      port_wdata_s = dl_data_s;
    end else if (up_req_s) begin
      grant_up_s  = 1'b1;
      port_addr_s = up_addr_s;
    end else begin
      port_addr_s = up_addr_s;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk_12) begin
    if (port_we_s) begin
      mem_r[port_addr_s] <= port_wdata_s;
    end
  end

  // Synchronous read into whichever requester won the port
  always_ff @(posedge clk_12) begin
    if (reset) begin
      cpu_dout_r  <= 8'h00;
      ioctl_din_r <= 8'hFF;
    end else begin
      if (grant_cpu_rd_s) begin
        cpu_dout_r <= mem_r[port_addr_s];
      end
      if (up_new_oor_s) begin
        ioctl_din_r <= 8'hFF;
      end else if (grant_up_s) begin
        ioctl_din_r <= mem_r[port_addr_s];
      end
    end
  end

  // Park HPS requests that lost arbitration for a retry next cycle
  always_ff @(posedge clk_12) begin
    if (reset) begin
      dl_pend_r      <= 1'b0;
      dl_pend_addr_r <= '0;
      dl_pend_data_r <= 8'h00;
      up_pend_r      <= 1'b0;
      up_pend_addr_r <= '0;
    end else begin
      dl_pend_r      <= dl_req_s & ~grant_dl_s;
      dl_pend_addr_r <= dl_addr_s;
      dl_pend_data_r <= dl_data_s;
      up_pend_r      <= up_req_s & ~grant_up_s;
      up_pend_addr_r <= up_addr_s;
    end
  end

  // Edge detection on the level inputs the FSM reacts to
  always_comb begin
    save_rise_s = save_trig & ~save_trig_d_r;
    up_rise_s   = ioctl_upload & ~upload_d_r & nv_sel_s;
    up_fall_s   = ~ioctl_upload & upload_d_r;
    dl_rise_s   = ioctl_download & ~download_d_r & nv_sel_s;
    dl_fall_s   = ~ioctl_download & download_d_r & nv_sel_s;
  end

  // Autosave FSM with registered upload request and dirty tracking
  always_ff @(posedge clk_12) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      upload_req_r   <= 1'b0;
      dirty_r        <= 1'b0;
      wr_during_up_r <= 1'b0;
      save_trig_d_r  <= 1'b0;
      upload_d_r     <= 1'b0;
      download_d_r   <= 1'b0;
    end else begin
      save_trig_d_r <= save_trig;
      upload_d_r    <= ioctl_upload;
      download_d_r  <= ioctl_download;

      case (state_r)
        ST_IDLE: begin
          if (up_rise_s) begin
            wr_during_up_r <= 1'b0;
            state_r        <= ST_UPLOADING;
          end else if (save_rise_s && dirty_r) begin
            upload_req_r <= 1'b1;
            state_r      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dl_rise_s) begin
            upload_req_r <= 1'b0;
            state_r      <= ST_IDLE;
          end else if (up_rise_s) begin
            upload_req_r   <= 1'b0;
            wr_during_up_r <= 1'b0;
            state_r        <= ST_UPLOADING;
          end
        end
        ST_UPLOADING: begin
          if (cpu_wr) begin
            wr_during_up_r <= 1'b1;
          end
          if (up_fall_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          upload_req_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase

      // A snapshot disturbed by a CPU write stays dirty after the save
      if (state_r == ST_DONE) begin
        dirty_r <= wr_during_up_r | cpu_wr;
      end else if (cpu_wr) begin
        dirty_r <= 1'b1;
      end else if (dl_fall_s) begin
        dirty_r <= 1'b0;
      end
    end
  end

  assign cpu_dout         = cpu_dout_r;
  assign ioctl_din        = ioctl_din_r;
  assign ioctl_upload_req = upload_req_r;
  assign dirty            = dirty_r;

endmodule

// File: tb/tb_earom_nvram_bridge.sv
// Self-checking bench for earom_nvram_bridge: table vectors after a restore,
// hand-written multi-cycle sequences, and a randomized phase checked
// against a plain array model of the shadow contents.
module tb_earom_nvram_bridge;

  logic        clk_12 = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_upload_req;
  logic        save_trig;
  logic [5:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        dirty;

  always #5 clk_12 = ~clk_12;

  earom_nvram_bridge #(.NV_INDEX(8'd4), .ADDR_W(6)) dut (
    .clk_12(clk_12), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din),
    .ioctl_upload_req(ioctl_upload_req), .save_trig(save_trig),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_dout(cpu_dout), .dirty(dirty)
  );

  typedef struct {
    logic        is_cpu;
    logic [24:0] addr;
    logic [7:0]  exp;
    string       nm;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model_mem [64];
  logic       wrote;
  vec_t       vecs [8];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_12);
    #1;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
    cycle();
    cpu_wr = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic cpu_read_chk(input logic [5:0] a, input logic [7:0] exp, input string nm);
    cpu_addr = a; cpu_rd = 1'b1;
    cycle();
    cpu_rd = 1'b0;
    check(nm, cpu_dout, exp);
  endtask

  // Upload read, checked three cycles after the strobe
  task automatic hps_rd_chk(input logic [24:0] a, input logic [7:0] exp, input string nm);
    ioctl_addr = a; ioctl_rd = 1'b1;
    cycle();
    ioctl_rd = 1'b0;
    cycle();
    cycle();
    check(nm, ioctl_din, exp);
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = 25'd0; ioctl_wr = 1'b0; ioctl_dout = 8'h00; ioctl_rd = 1'b0;
    save_trig = 1'b0; cpu_addr = 6'd0; cpu_din = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
    wrote = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;

    vecs[0] = '{1'b1, 25'd10,     8'h0A, "cpu_rd_10"};
    vecs[1] = '{1'b1, 25'd0,      8'h00, "cpu_rd_0_not_wrapped"};
    vecs[2] = '{1'b1, 25'd63,     8'h3F, "cpu_rd_63"};
    vecs[3] = '{1'b0, 25'd5,      8'h05, "up_rd_5"};
    vecs[4] = '{1'b0, 25'd64,     8'hFF, "up_rd_64"};
    vecs[5] = '{1'b0, 25'd63,     8'h3F, "up_rd_63"};
    vecs[6] = '{1'b0, 25'h01000,  8'hFF, "up_rd_far"};
    vecs[7] = '{1'b0, 25'd0,      8'h00, "up_rd_0"};

    repeat (3) cycle();
    check("rst_ioctl_din", ioctl_din, 8'hFF);
    check("rst_cpu_dout", cpu_dout, 8'h00);
    check("rst_upload_req", {7'd0, ioctl_upload_req}, 8'h00);
    check("rst_dirty", {7'd0, dirty}, 8'h00);
    reset = 1'b0;
    cycle();

    // Dirty the shadow, then restore it
    cpu_write(6'd20, 8'h99);
    check("dirty_after_cpu_wr", {7'd0, dirty}, 8'h01);
    ioctl_index = 8'd4; ioctl_download = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = (i < 64) ? 8'(i) : 8'hAA;
      ioctl_wr = 1'b1;
      cycle();
      ioctl_wr = 1'b0;
      cycle();
      if (i < 64) model_mem[i] = 8'(i);
    end
    ioctl_download = 1'b0;
    cycle();
    check("dirty_after_restore", {7'd0, dirty}, 8'h00);

    // Vector table with the upload active
    ioctl_upload = 1'b1;
    cycle();
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].is_cpu) cpu_read_chk(vecs[v].addr[5:0], vecs[v].exp, vecs[v].nm);
      else hps_rd_chk(vecs[v].addr, vecs[v].exp, vecs[v].nm);
    end

    // Foreign index leaves ioctl_din alone
    ioctl_index = 8'd0;
    hps_rd_chk(25'd5, 8'h00, "up_rd_wrong_index");
    ioctl_index = 8'd4;

    // Worst case: CPU write then CPU read both beat the HPS read
    ioctl_addr = 25'd9; ioctl_rd = 1'b1;
    cpu_addr = 6'd30; cpu_din = 8'h31; cpu_wr = 1'b1;
    cycle();
    ioctl_rd = 1'b0; cpu_wr = 1'b0; model_mem[30] = 8'h31;
    cpu_addr = 6'd30; cpu_rd = 1'b1;
    cycle();
    cpu_rd = 1'b0;
    check("worst_cpu_rd", cpu_dout, 8'h31);
    cycle();
    check("worst_up_rd_latency", ioctl_din, 8'h09);
    ioctl_upload = 1'b0;
    cycle(); cycle();
    check("dirty_kept_after_hps_upload", {7'd0, dirty}, 8'h01);

    // Autosave round trip
    cpu_write(6'd3, 8'h5A);
    save_trig = 1'b1;
    cycle();
    check("autosave_req", {7'd0, ioctl_upload_req}, 8'h01);
    ioctl_upload = 1'b1;
    cycle();
    check("autosave_req_drop", {7'd0, ioctl_upload_req}, 8'h00);
    hps_rd_chk(25'd3, 8'h5A, "autosave_rd_3");
    ioctl_upload = 1'b0;
    cycle(); cycle();
    check("autosave_dirty_clear", {7'd0, dirty}, 8'h00);

    // save_trig with dirty=0, then held level gives no new request
    save_trig = 1'b0; cycle();
    save_trig = 1'b1; cycle(); cycle();
    check("save_clean_ignored", {7'd0, ioctl_upload_req}, 8'h00);
    cpu_write(6'd40, 8'h12);
    cycle(); cycle();
    check("save_level_no_req", {7'd0, ioctl_upload_req}, 8'h00);
    save_trig = 1'b0; cycle();
    save_trig = 1'b1; cycle();
    check("save_second_edge_req", {7'd0, ioctl_upload_req}, 8'h01);

    // CPU write and HPS read to the same address in one cycle
    ioctl_upload = 1'b1;
    cycle();
    ioctl_addr = 25'd7; ioctl_rd = 1'b1;
    cpu_addr = 6'd7; cpu_din = 8'h77; cpu_wr = 1'b1;
    cycle();
    ioctl_rd = 1'b0; cpu_wr = 1'b0; model_mem[7] = 8'h77;
    cycle(); cycle();
    check("collide_up_rd_new", ioctl_din, 8'h77);
    ioctl_upload = 1'b0;
    cycle(); cycle();
    check("collide_dirty_stays", {7'd0, dirty}, 8'h01);
    save_trig = 1'b0; cycle();

    // Reset while in REQ
    save_trig = 1'b1; cycle();
    check("pre_reset_req", {7'd0, ioctl_upload_req}, 8'h01);
    reset = 1'b1; cycle();
    check("reset_req_clear", {7'd0, ioctl_upload_req}, 8'h00);
    check("reset_dirty_clear", {7'd0, dirty}, 8'h00);
    reset = 1'b0; save_trig = 1'b0; cycle();
    cpu_read_chk(6'd7, 8'h77, "ram_kept_over_reset");

    // Reset mid-upload; reads remain served
    ioctl_upload = 1'b1; cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    hps_rd_chk(25'd3, 8'h5A, "rd_after_mid_reset");
    ioctl_upload = 1'b0; cycle(); cycle();

    // Randomized mix of CPU traffic and upload reads
    ioctl_upload = 1'b1; cycle();
    wrote = 1'b0;
    for (int it = 0; it < 150; it++) begin
      logic [24:0] ha;
      logic [7:0]  hexp;
      ha = ($urandom_range(0, 9) == 0) ? 25'(64 + $urandom_range(0, 500))
                                        : 25'($urandom_range(0, 63));
      hexp = (ha < 25'd64) ? model_mem[ha[5:0]] : 8'hFF;
      for (int s = 0; s < 3; s++) begin
        int         op;
        logic [5:0] ca;
        logic [7:0] cd;
        op = (s == 2) ? 0 : int'($urandom_range(0, 2));
        ca = 6'($urandom_range(0, 63));
        if (op == 1 && ha < 25'd64 && ca == ha[5:0]) ca = ca + 6'd1;
        cd = 8'($urandom);
        ioctl_addr = ha; ioctl_rd = (s == 0);
        cpu_addr = ca; cpu_din = cd; cpu_wr = (op == 1); cpu_rd = (op == 2);
        cycle();
        ioctl_rd = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        if (op == 1) begin
          model_mem[ca] = cd;
          wrote = 1'b1;
        end
        if (op == 2) check("rand_cpu_rd", cpu_dout, model_mem[ca]);
      end
      check("rand_up_rd", ioctl_din, hexp);
    end
    ioctl_upload = 1'b0;
    cycle(); cycle();
    check("rand_dirty", {7'd0, dirty}, {7'd0, wrote});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
